// File: rtl/dsp_cic_dec_if.sv
// Sample-stream bundle for dsp_cic_dec: one input sample per clock in, and a
// decimated full-precision / reduced-width result with a one-cycle valid pulse out.
interface dsp_cic_dec_if #(
    parameter int unsigned BIN  = 10,
    parameter int unsigned BOUT = 30,
    parameter int unsigned COUT = 16
);
    logic signed [BIN-1:0]  din;
    logic signed [BOUT-1:0] dout;
    logic signed [COUT-1:0] dout_cut;
    logic                   dout_vld;

    // Sample source / result consumer.
    modport master (
        output din,
        input  dout,
        input  dout_cut,
        input  dout_vld
    );

    // Filter side.
    modport slave (
        input  din,
        output dout,
        output dout_cut,
        output dout_vld
    );
endinterface

// File: rtl/dsp_cic_dec.sv
// N-stage CIC decimator: integrators at clk rate, decimate by R, N comb stages
// with differential delay M. Full-precision dout plus a COUT-bit dout_cut
// reduced by rounding (half up) or truncation (floor).
// Build option: define DSP_CIC_DEC_ROUND_SAT_EN to make a "ROUND" result that
// overflows COUT bits saturate to the largest positive value instead of wrapping.
module dsp_cic_dec #(
    parameter int unsigned R          = 100,
    parameter int unsigned M          = 1,
    parameter int unsigned N          = 3,
    parameter int unsigned BIN        = 10,
    parameter int unsigned COUT       = 16,
    parameter int unsigned BOUT       = BIN + $clog2(longint'(R * M) ** N),
    parameter string       CUT_METHOD = "ROUND"
) (
    input logic           clk,
    input logic           rst,
    dsp_cic_dec_if.slave  bus
);

    localparam int unsigned CntW = $clog2(R);
    localparam int unsigned S    = BOUT - COUT;

    logic [CntW-1:0] cnt_q;
    logic            strobe;

    logic [BOUT-1:0] din_ext;
    logic [BOUT-1:0] integ_q [N];

    logic [BOUT-1:0] comb_in   [N];
    logic [BOUT-1:0] comb_next [N];
    logic [BOUT-1:0] comb_q    [N];
    logic [BOUT-1:0] dly_q     [N][M];
    logic [BOUT-1:0] last_next;

    logic [COUT-1:0] cut_next;
    logic [COUT-1:0] cut_q;
    logic            vld_q;

    // Sign-extend the input to the full accumulator width.
    assign din_ext = BOUT'(bus.din);

    // Strobe on the last count of each decimation period.
    assign strobe = (cnt_q == CntW'(R - 1));

    // Decimation counter: 0..R-1, wraps to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (strobe) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    // Integrator cascade; overflow wraps, the combs cancel it exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(N); k++) begin
                integ_q[k] <= '0;
            end
        end else begin
            integ_q[0] <= integ_q[0] + din_ext;
            for (int k = 1; k < int'(N); k++) begin
                integ_q[k] <= integ_q[k] + integ_q[k-1];
            end
        end
    end

    // Comb stage inputs and differences, one pipeline register per stage.
    for (genvar k = 0; k < int'(N); k++) begin : g_comb
        if (k == 0) begin : g_first
            assign comb_in[k] = integ_q[N-1];
        end else begin : g_rest
            assign comb_in[k] = comb_q[k-1];
        end
        assign comb_next[k] = comb_in[k] - dly_q[k][M-1];
    end

    assign last_next = comb_next[N-1];

    // Output width reduction, computed from the value about to land in dout.
    if (S == 0) begin : g_cut_pass
        assign cut_next = last_next;
    end else if (CUT_METHOD == "TRUNC") begin : g_cut_trunc
        // Keeping the top COUT bits of a logical shift equals an arithmetic floor shift.
        assign cut_next = COUT'(last_next >> S);
    end else begin : g_cut_round
`ifdef DSP_CIC_DEC_ROUND_SAT_EN
        // One extra bit so a carry out of the rounding add is visible as overflow.
        localparam logic [BOUT:0] HalfW = (BOUT + 1)'(1) << (S - 1);
        logic [COUT:0] rnd_top;
        assign rnd_top  = (COUT + 1)'(({last_next[BOUT-1], last_next} + HalfW) >> S);
        // Adding +half can only overflow upward, so only positive saturation is needed.
        assign cut_next = (rnd_top[COUT] != rnd_top[COUT-1]) ?
                          {1'b0, {(COUT - 1){1'b1}}} : rnd_top[COUT-1:0];
`else
        localparam logic [BOUT-1:0] Half = BOUT'(1) << (S - 1);
        // Sum wraps in BOUT bits, so an overflowing result wraps modulo 2^COUT.
        assign cut_next = COUT'((last_next + Half) >> S);
`endif
    end

    // Comb pipeline, delay lines and output registers advance only on the strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(N); k++) begin
                comb_q[k] <= '0;
                for (int j = 0; j < int'(M); j++) begin
                    dly_q[k][j] <= '0;
                end
            end
            cut_q <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= strobe;
            if (strobe) begin
                for (int k = 0; k < int'(N); k++) begin
                    comb_q[k]   <= comb_next[k];
                    dly_q[k][0] <= comb_in[k];
                    for (int j = 1; j < int'(M); j++) begin
                        dly_q[k][j] <= dly_q[k][j-1];
                    end
                end
                cut_q <= cut_next;
            end
        end
    end

    assign bus.dout     = comb_q[N-1];
    assign bus.dout_cut = cut_q;
    assign bus.dout_vld = vld_q;

endmodule

// File: tb/tb_dsp_cic_dec.sv
// Scoreboard bench for dsp_cic_dec (R=100, M=1, N=3, BIN=10, COUT=16, BOUT=30).
// A ROUND and a TRUNC instance share din/rst; expected outputs per pulse are queued
// by the stimulus and checked by an independent monitor on each dout_vld.
module tb_dsp_cic_dec;

    localparam int R = 100;

    typedef struct {
        bit     chk;
        longint dout;
        longint rnd;
        longint trn;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic signed [9:0]   din = '0;

    exp_t   sb_q [$];
    int     n_chk  = 0;
    int     n_pass = 0;
    int     vld_cnt = 0;
    longint cyc  = 0;
    longint last = 0;

    dsp_cic_dec_if #(.BIN(10), .BOUT(30), .COUT(16)) bus_r ();
    dsp_cic_dec_if #(.BIN(10), .BOUT(30), .COUT(16)) bus_t ();

    assign bus_r.din = din;
    assign bus_t.din = din;

    dsp_cic_dec #(.R(100), .M(1), .N(3), .BIN(10), .COUT(16), .CUT_METHOD("ROUND")) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_r)
    );

    dsp_cic_dec #(.R(100), .M(1), .N(3), .BIN(10), .COUT(16), .CUT_METHOD("TRUNC")) u_dut_t (
        .clk (clk),
        .rst (rst),
        .bus (bus_t)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                check("rst_vld", longint'(bus_r.dout_vld), 0);
                check("rst_dout", longint'(bus_r.dout), 0);
                check("rst_cut", longint'(bus_r.dout_cut), 0);
                check("rst_cut_trunc", longint'(bus_t.dout_cut), 0);
                last = cyc;
            end else if (bus_r.dout_vld) begin
                vld_cnt++;
                check("vld_spacing", cyc - last, R);
                last = cyc;
                check("trunc_vld_align", longint'(bus_t.dout_vld), 1);
                check("sb_nonempty", longint'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    if (e.chk) begin
                        check("dout", longint'(bus_r.dout), e.dout);
                        check("dout_cut_round", longint'(bus_r.dout_cut), e.rnd);
                        check("dout_trunc_inst", longint'(bus_t.dout), e.dout);
                        check("dout_cut_trunc", longint'(bus_t.dout_cut), e.trn);
                    end
                end
            end
        end
    end

    // One-cycle reset, then constant din for a number of decimation periods.
    // The first 5 pulses are comb start-up transient and are only counted.
    task automatic run_const(input logic signed [9:0] d, input longint e_dout,
                             input longint e_rnd, input longint e_trn,
                             input int pulses, input int extra);
        exp_t e;
        int   n0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < pulses; i++) begin
            e.chk  = (i >= 5);
            e.dout = e_dout;
            e.rnd  = e_rnd;
            e.trn  = e_trn;
            sb_q.push_back(e);
        end
        @(negedge clk);
        rst = 1'b0;
        din = d;
        n0  = vld_cnt;
        repeat (pulses * R) @(posedge clk);
        @(negedge clk);
        check("pulse_count", longint'(vld_cnt - n0), pulses);
        check("sb_drained", longint'(sb_q.size()), 0);
        repeat (extra) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        //        din    dout        round   trunc   pulses extra
        run_const(10'sd1,    1000000,     61,     61,    10, 37);
        // Reset lands mid-period here; behaviour must match power-up.
        run_const(10'sd1,    1000000,     61,     61,    10,  0);
        run_const(-10'sd1,   -1000000,   -61,    -62,    10,  0);
        run_const(-10'sd512, -512000000, -31250, -31250, 10,  0);
        // 511e6 / 2^14 = 31188.97: round half up gives 31189, floor gives 31188.
        run_const(10'sd511,  511000000,  31189,  31188,  10,  0);
        run_const(10'sd37,   37000000,   2258,   2258,   10,  0);
        run_const(-10'sd37,  -37000000,  -2258,  -2259,  10,  0);
        // 10000-clock free run: exactly 100 pulses, spacing checked by the monitor.
        run_const(10'sd0,    0,          0,      0,      100, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d of %0d checks passed",
                 n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
